serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned/signed subtractor, one result bit per clock
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Per-bit full-subtractor cell on the operand LSBs
    logic             bit_d;
    logic             bit_bw;
    logic [WIDTH-1:0] r_next;

    // Combinational bit cell: difference bit, outgoing borrow, next result word
    always_comb begin
        bit_d  = a_q[0] ^ b_q[0] ^ bw_q;
        bit_bw = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
        r_next = {bit_d, r_q[WIDTH-1:1]};
    end

    // Next-state and next-output logic; results are published on entry to DONE,
    // and done_o is raised on the DONE->IDLE edge so it pulses in the first IDLE cycle
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
                    r_d     = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                r_d   = r_next;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bw_d  = bit_bw;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = r_next;
                    borrow_d = bit_bw;
                    ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign diff_o   = diff_q;
    assign borrow_o = borrow_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         ovf_o;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bw;
        logic         ov;
    } res_t;

    res_t exp_q[$];
    res_t hold = '0;
    res_t popped;
    int   busy_cnt = 0;
    logic exp_done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   cyc = 0;
    int   last_done = -1;
    bit   sweep_on = 1'b0;
    int   dc_before;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .diff_o  (diff_o),
        .borrow_o(borrow_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        r.d  = a - b;
        r.bw = (a < b);
        r.ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r.d[W-1]);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Reference timing model: accept in idle, then W+1 busy cycles, done pulse after
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            busy_cnt = 0;
            exp_done = 1'b0;
            hold     = '0;
            exp_q.delete();
        end else begin
            exp_done = 1'b0;
            if (busy_cnt == 0 && start_i) begin
                exp_q.push_back(model(a_i, b_i));
                busy_cnt = W + 1;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) exp_done = 1'b1;
            end
        end
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        checks++;
        assert (busy_o === (busy_cnt != 0)) else begin
            errors++;
            $error("FAIL busy: got %0b want %0b", busy_o, (busy_cnt != 0));
        end
        checks++;
        assert (done_o === exp_done) else begin
            errors++;
            $error("FAIL done: got %0b want %0b", done_o, exp_done);
        end
        if (done_o) done_count++;
        if (exp_done) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard_empty: got %0d want >0", exp_q.size());
            end
            if (exp_q.size() > 0) begin
                popped = exp_q.pop_front();
                hold   = popped;
            end
            if (sweep_on) begin
                if (last_done >= 0) begin
                    checks++;
                    assert ((cyc - last_done) === W + 2) else begin
                        errors++;
                        $error("FAIL spacing: got %0d want %0d", cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
            end
        end
        if (busy_cnt != 1) begin
            checks++;
            assert ({diff_o, borrow_o, ovf_o} === hold) else begin
                errors++;
                $error("FAIL result: got d=%0h bw=%0b ov=%0b want d=%0h bw=%0b ov=%0b",
                       diff_o, borrow_o, ovf_o, hold.d, hold.bw, hold.ov);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (W + 3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        checks++;
        assert ({busy_o, done_o, diff_o, borrow_o, ovf_o} === '0) else begin
            errors++;
            $error("FAIL reset_outputs: got %0h want 0", {busy_o, done_o, diff_o, borrow_o, ovf_o});
        end

        // Start presented at the first edge after reset release
        a_i     = 8'h05;
        b_i     = 8'h03;
        start_i = 1'b1;
        rst_i   = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Directed corner operands
        run_op(8'h03, 8'h05);
        run_op(8'h00, 8'h01);
        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'hFF);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'h00);

        // Start and operand changes while busy are ignored
        dc_before = done_count;
        @(negedge clk);
        a_i     = 8'h10;
        b_i     = 8'h01;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        a_i     = 8'hAA;
        b_i     = 8'h55;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = 8'h00;
        b_i     = 8'hC3;
        repeat (W + 6) @(negedge clk);
        checks++;
        assert (done_count === dc_before + 1) else begin
            errors++;
            $error("FAIL single_done: got %0d want %0d", done_count - dc_before, 1);
        end

        // Reset four cycles into SHIFT
        dc_before = done_count;
        @(negedge clk);
        a_i     = 8'h5A;
        b_i     = 8'h21;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        assert ({busy_o, done_o, diff_o, borrow_o, ovf_o} === '0) else begin
            errors++;
            $error("FAIL async_reset: got %0h want 0", {busy_o, done_o, diff_o, borrow_o, ovf_o});
        end
        @(negedge clk);
        rst_i   = 1'b0;
        a_i     = 8'h33;
        b_i     = 8'h33;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (W + 3) @(negedge clk);
        checks++;
        assert (done_count === dc_before + 1) else begin
            errors++;
            $error("FAIL abandon_done: got %0d want %0d", done_count - dc_before, 1);
        end
        checks++;
        assert ({diff_o, borrow_o, ovf_o} === {8'h00, 1'b0, 1'b0}) else begin
            errors++;
            $error("FAIL equal_after_reset: got %0h want 0", {diff_o, borrow_o, ovf_o});
        end

        // Back-to-back sweep with start held high
        dc_before = done_count;
        sweep_on  = 1'b1;
        last_done = -1;
        start_i   = 1'b1;
        a_i       = W'($urandom);
        b_i       = W'($urandom);
        for (int i = 0; i < 1000 * (W + 2); i++) begin
            @(negedge clk);
            a_i = W'($urandom);
            b_i = W'($urandom);
        end
        start_i = 1'b0;
        repeat (W + 4) @(negedge clk);
        sweep_on = 1'b0;
        checks++;
        assert (done_count === dc_before + 1000) else begin
            errors++;
            $error("FAIL sweep_count: got %0d want %0d", done_count - dc_before, 1000);
        end
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
